// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Boot-time loader for the single-cycle CPU. It packs a byte
//             stream into 32-bit instruction words, writes them to the
//             instruction memory and zero-fills the remaining words. It then
//             holds the CPU start input high for a fixed number of cycles and
//             raises a sticky done flag.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int MEM_DEPTH  = 128,
  parameter int ADDR_W     = 7,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  run_cycle_o
);

  // Word counters need one extra bit so they can hold MEM_DEPTH itself.
  localparam int                c_PW      = ADDR_W + 1;
  // The header byte is compared at a width that holds both it and MEM_DEPTH.
  localparam int                c_HW      = (c_PW > 8) ? c_PW : 8;
  localparam logic [c_PW-1:0]   c_DEPTH   = c_PW'(MEM_DEPTH);
  localparam logic [c_HW-1:0]   c_DEPTH_H = c_HW'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]  c_LAST    = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_FILL = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_rdy_en;
  logic [c_PW-1:0] r_nwords;
  logic [c_PW-1:0] r_word_idx;
  logic [c_PW-1:0] r_fill_ptr;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_pack;

  logic            w_accept;
  logic [c_HW-1:0] w_hdr;
  logic [c_HW-1:0] w_hdr_clamp;
  logic            w_last_word;

  assign byte_ready_o = r_rdy_en & ((r_state == S_HDR) | (r_state == S_LOAD));
  assign w_accept     = byte_valid_i & byte_ready_o;
  assign w_hdr        = c_HW'(byte_data_i);
  assign w_hdr_clamp  = (w_hdr > c_DEPTH_H) ? c_DEPTH_H : w_hdr;
  assign w_last_word  = ((r_word_idx + c_PW'(1)) == r_nwords);

  // Keep the handshake closed until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // Loader sequencer: header, word packing, zero fill, timed CPU run.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_HDR;
      r_nwords    <= '0;
      r_word_idx  <= '0;
      r_fill_ptr  <= '0;
      r_byte_cnt  <= '0;
      r_pack      <= '0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      start_o     <= 1'b0;
      done_o      <= 1'b0;
      run_cycle_o <= '0;
    end else begin
      imem_we_o <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            r_nwords   <= w_hdr_clamp[c_PW-1:0];
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            if (w_hdr_clamp == '0) begin
              r_fill_ptr <= '0;
              r_state    <= S_FILL;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Fourth byte completes the big-endian word.
              imem_we_o   <= 1'b1;
              imem_addr_o <= r_word_idx[ADDR_W-1:0];
              imem_data_o <= {r_pack, byte_data_i};
              r_word_idx  <= r_word_idx + c_PW'(1);
              if (w_last_word) begin
                r_fill_ptr <= r_nwords;
                r_state    <= S_FILL;
              end
            end else begin
              r_pack <= {r_pack[15:0], byte_data_i};
            end
          end
        end
        S_FILL: begin
          if (r_fill_ptr < c_DEPTH) begin
            imem_we_o   <= 1'b1;
            imem_addr_o <= r_fill_ptr[ADDR_W-1:0];
            imem_data_o <= '0;
            r_fill_ptr  <= r_fill_ptr + c_PW'(1);
          end else begin
            start_o     <= 1'b1;
            run_cycle_o <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (run_cycle_o == c_LAST) begin
            start_o <= 1'b0;
            done_o  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            run_cycle_o <= run_cycle_o + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_HDR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Brief    : Directed bench for imem_loader with a write scoreboard and
//             run-phase timing checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int MEM_DEPTH  = 128;
  localparam int ADDR_W     = 7;
  localparam int MAX_CYCLES = 30;
  localparam int CNT_W      = 16;

  logic              clk_i        = 1'b0;
  logic              rst_i        = 1'b1;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_data_i  = 8'h00;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              start_o;
  logic              done_o;
  logic [CNT_W-1:0]  run_cycle_o;

  imem_loader #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W),
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .start_o     (start_o),
    .done_o      (done_o),
    .run_cycle_o (run_cycle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cnt, last_acc, wr_cnt, first_wr, last_wr;
  int start_rise, start_fall, done_rise, start_hi;
  logic prev_start, prev_done;

  logic [38:0] exp_q[$];
  logic [7:0]  tx[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({byte_ready_o, imem_we_o, imem_addr_o, imem_data_o,
                    start_o, done_o, run_cycle_o}), 64'(0));
  endtask

  // Per-cycle observation: scoreboard pop on writes, start/done edge tracking.
  task automatic monitor();
    logic [38:0] e;
    if (imem_we_o) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      check("wr_pending", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr_data", 64'({imem_addr_o, imem_data_o}), 64'(e));
      end
    end
    if (start_o && !prev_start) start_rise = cyc;
    if (!start_o && prev_start) start_fall = cyc;
    if (done_o && !prev_done)   done_rise  = cyc;
    if (start_o) begin
      start_hi++;
      check("run_cycle", 64'(run_cycle_o), 64'(cyc - start_rise));
    end
    prev_start = start_o;
    prev_done  = done_o;
  endtask

  // Advance one clock; inputs are stable between negedges so acceptance is
  // decided by what is visible now.
  task automatic tick();
    bit acc;
    acc = byte_valid_i && byte_ready_o && rst_i;
    @(negedge clk_i);
    cyc++;
    if (acc) begin
      acc_cnt++;
      last_acc = cyc;
    end
    monitor();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    int w;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin
      byte_valid_i = 1'b0;
      byte_data_i  = 8'($urandom);
      tick();
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    w = 0;
    while (!byte_ready_o && w < 20) begin
      tick();
      w++;
    end
    check("ready_before_accept", 64'(byte_ready_o), 64'(1));
    tick();
  endtask

  task automatic send_stream(input int gapmax);
    foreach (tx[i]) send_byte(tx[i], gapmax);
    byte_valid_i = 1'b0;
  endtask

  task automatic push_zeros(input int from);
    for (int k = from; k < MEM_DEPTH; k++) exp_q.push_back({7'(k), 32'h0});
  endtask

  task automatic push_load(input int hdr);
    int n;
    n = (hdr > MEM_DEPTH) ? MEM_DEPTH : hdr;
    for (int k = 0; k < n; k++)
      exp_q.push_back({7'(k), tx[1+4*k], tx[2+4*k], tx[3+4*k], tx[4+4*k]});
    push_zeros(n);
  endtask

  task automatic do_reset(input int n);
    byte_valid_i = 1'b0;
    rst_i        = 1'b0;
    #1;
    check_zero("rst_immediate");
    repeat (n) begin
      tick();
      check_zero("rst_hold");
    end
    rst_i      = 1'b1;
    acc_cnt    = 0;
    last_acc   = -1;
    wr_cnt     = 0;
    first_wr   = -1;
    last_wr    = -1;
    start_rise = -1;
    start_fall = -1;
    done_rise  = -1;
    start_hi   = 0;
    prev_start = 1'b0;
    prev_done  = 1'b0;
    check("ready_low_1st_edge", 64'(byte_ready_o), 64'(0));
    tick();
    check("ready_high_2nd_edge", 64'(byte_ready_o), 64'(1));
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int w;
    w = 0;
    while (!done_o && w < budget) begin
      if (rnd) begin
        byte_valid_i = 1'($urandom);
        byte_data_i  = 8'($urandom);
      end
      tick();
      w++;
    end
    check("done_reached", 64'(done_o), 64'(1));
    repeat (3) tick();
    check("done_sticky", 64'(done_o), 64'(1));
    byte_valid_i = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n_acc, input int lat);
    check({tag, "_pending"},   64'(exp_q.size()), 64'(0));
    check({tag, "_writes"},    64'(wr_cnt), 64'(MEM_DEPTH));
    check({tag, "_accepted"},  64'(acc_cnt), 64'(n_acc));
    check({tag, "_start_lat"}, 64'(start_rise - last_acc), 64'(lat));
    check({tag, "_start_len"}, 64'(start_fall - start_rise), 64'(MAX_CYCLES));
    check({tag, "_start_hi"},  64'(start_hi), 64'(MAX_CYCLES));
    check({tag, "_done_edge"}, 64'(done_rise - start_fall), 64'(0));
    check({tag, "_run_final"}, 64'(run_cycle_o), 64'(MAX_CYCLES - 1));
    check({tag, "_start_low"}, 64'(start_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_i);

    // Reset and idle: nothing accepted or written while valid is low.
    do_reset(3);
    repeat (5) begin
      byte_valid_i = 1'b0;
      byte_data_i  = 8'($urandom);
      tick();
    end
    check("idle_writes", 64'(wr_cnt), 64'(0));
    check("idle_accepted", 64'(acc_cnt), 64'(0));
    check("idle_ready", 64'(byte_ready_o), 64'(1));

    // Two-word program.
    tx = {8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    exp_q.push_back({7'd0, 32'h20080005});
    exp_q.push_back({7'd1, 32'h01095020});
    push_zeros(2);
    send_stream(0);
    wait_done(400, 1'b0);
    check_run("two_word", 9, 127);

    // Empty program: pure zero fill on consecutive cycles.
    do_reset(2);
    tx = {8'h00};
    push_zeros(0);
    send_stream(0);
    wait_done(400, 1'b0);
    check_run("empty", 1, 129);
    check("empty_first_wr", 64'(first_wr - last_acc), 64'(1));
    check("empty_wr_span", 64'(last_wr - first_wr), 64'(MEM_DEPTH - 1));

    // Header above depth is clamped; surplus bytes are refused.
    do_reset(2);
    tx = {8'hC8};
    for (int i = 0; i < 4 * MEM_DEPTH; i++) tx.push_back(8'($urandom));
    push_load(200);
    send_stream(0);
    for (int i = 0; i < 4; i++) begin
      byte_valid_i = 1'b1;
      byte_data_i  = 8'($urandom);
      check("clamp_extra_ready", 64'(byte_ready_o), 64'(0));
      tick();
    end
    wait_done(400, 1'b1);
    check_run("clamp", 1 + 4 * MEM_DEPTH, 1);

    // Gaps with junk data, then random traffic during fill and run.
    do_reset(2);
    tx = {8'h06};
    for (int i = 0; i < 24; i++) tx.push_back(8'($urandom));
    push_load(6);
    send_stream(3);
    wait_done(400, 1'b1);
    check_run("gaps", 25, 123);

    // Reset in the middle of a load, then a clean reload.
    do_reset(2);
    tx = {8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_q.push_back({7'd0, 32'h11223344});
    send_stream(0);
    check("midload_pending", 64'(exp_q.size()), 64'(0));
    check("midload_writes", 64'(wr_cnt), 64'(1));
    do_reset(2);
    tx = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back({7'd0, 32'hDEADBEEF});
    push_zeros(1);
    send_stream(0);
    wait_done(400, 1'b0);
    check_run("reload", 5, 128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that sits directly upstream of the single-cycle CPU. It receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words. Each word is written into the instruction memory, and all remaining memory words are zero-filled. It then drives the CPU's start input for a fixed number of cycles and reports completion. This replaces preloading the instruction memory and hand-driving start/stop in the test environment.

## Interface
Parameters:
- MEM_DEPTH, 128: instruction memory depth in words.
- ADDR_W, 7: word-address width; 2^ADDR_W >= MEM_DEPTH.
- MAX_CYCLES, 30: number of cycles start_o is held high; must be >= 1.
- CNT_W, 16: run-counter width; 2^CNT_W > MAX_CYCLES.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-low.
- byte_valid_i, in, 1: byte_data_i is valid.
- byte_data_i, in, 8: stream byte.
- byte_ready_o, out, 1: loader accepts a byte this cycle.
- imem_we_o, out, 1: instruction-memory write strobe (registered).
- imem_addr_o, out, ADDR_W: word address of the write (registered).
- imem_data_o, out, 32: write data (registered).
- start_o, out, 1: drives CPU start_i (registered).
- done_o, out, 1: run finished; sticky until reset.
- run_cycle_o, out, CNT_W: cycles elapsed in RUN.

## Operation
- Handshake: a byte is accepted on a rising edge with byte_valid_i & byte_ready_o. byte_data_i is ignored when not accepted.
- byte_ready_o = rdy_en_q & (state==HDR | state==LOAD). rdy_en_q clears in reset and sets on the first edge after rst_i rises.
- States:
  - HDR (reset state):
    - First accepted byte is the word count N, clamped to MEM_DEPTH.
    - N=0: go to FILL with fill_ptr=0.
    - N>0: go to LOAD.
  - LOAD:
    - Bytes are packed big-endian: 1st byte goes to [31:24], 4th byte to [7:0].
    - On the 4th byte of word k: imem_we_o<=1, imem_addr_o<=k, imem_data_o<=packed word.
    - After the 4th byte of word N-1: go to FILL with fill_ptr=N.
  - FILL:
    - Each edge with fill_ptr<MEM_DEPTH: imem_we_o<=1, addr<=fill_ptr, data<=0, then fill_ptr++.
    - Edge with fill_ptr==MEM_DEPTH: imem_we_o<=0, start_o<=1, run_cycle_o<=0, go to RUN.
  - RUN:
    - run_cycle_o increments each edge.
    - On the edge where run_cycle_o==MAX_CYCLES-1: start_o<=0, done_o<=1, go to DONE. run_cycle_o holds MAX_CYCLES-1.
  - DONE: terminal state; leaves only via reset.
- fill_ptr is ADDR_W+1 bits wide and never wraps. A byte counter (2 bits) wraps 3->0 per word.
- No bytes are accepted outside HDR/LOAD. Bytes beyond N*4, and bytes offered in FILL/RUN/DONE, stay unaccepted (ready=0).
- imem_we_o is low in every cycle not explicitly set above.
- Reset, asserted at any time including mid-operation:
  - All outputs 0, state HDR, counters 0.
  - Memory contents are not cleared by reset; the next load rewrites every word.

## Timing
- Reset values: byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_data_o=0, start_o=0, done_o=0, run_cycle_o=0.
- First byte is acceptable at the 2nd rising edge after rst_i deasserts.
- Write latency: imem_we_o is high in the cycle after acceptance of a word's 4th byte, for exactly 1 cycle per word.
- Back-to-back 4th bytes give writes on consecutive cycles.
- Let t = cycle of the last accepted byte (the header when N=0):
  - FILL writes occupy cycles t+2 .. t+1+(MEM_DEPTH-N).
  - start_o rises at cycle t+2+(MEM_DEPTH-N).
  - For N=MEM_DEPTH there are no fill writes; start_o rises at t+2, right after the last-word write at t+1.
- start_o is high for exactly MAX_CYCLES consecutive cycles. done_o rises in the cycle start_o falls.
- Every address 0..MEM_DEPTH-1 is written exactly once per load.

## Test plan
- Reset/idle: hold rst_i=0 for 3 cycles, then release.
  - All outputs stay 0 during reset.
  - byte_ready_o=1 from the 2nd edge after release.
  - Nothing is written while byte_valid_i=0.
- Two-word load: stream 0x02, 20 08 00 05, 01 09 50 20.
  - Writes addr0=0x20080005, then addr1=0x01095020.
  - Zero writes to addr 2..127.
  - start_o rises at t+128 and is high for 30 cycles; then done_o=1 and run_cycle_o=29.
- Empty program: header 0x00.
  - 128 zero writes to addr 0..127 on consecutive cycles.
  - start_o rises at t+130.
- Clamp/overrun: header 0xC8 (200), then 512 bytes plus 4 extra.
  - Exactly 513 bytes accepted (header plus 512); byte_ready_o=0 afterwards.
  - No FILL writes; start_o rises at t+2.
- Backpressure/gaps: randomize byte_valid_i with changing junk data while valid=0.
  - Packed words are unaffected.
  - Bytes offered during RUN are not accepted and do not affect run_cycle_o.
- Mid-load reset: pull rst_i low after header 0x03 plus 5 bytes.
  - Outputs go to 0 immediately.
  - After release, a fresh 0x01, DE AD BE EF writes addr0=0xDEADBEEF; no stale partial word appears.
